// File: rtl/seq_loop_pkg.sv
// Shared types for the sequential-loop tracker: FSM state encoding and the
// post-loop successor bundle with its match helper.
package seq_loop_pkg;

  // Tracker FSM states.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StInLoop = 2'd1,
    StDone   = 2'd2
  } loop_state_e;

  localparam int unsigned NUM_POST_STATES = 5;

  // Post states are carried zero-extended to a fixed width so the bundle type
  // does not depend on the tracker's FSM_WIDTH (supports FSM_WIDTH up to 16).
  localparam int unsigned POST_STATE_W = 16;

  typedef struct packed {
    logic [NUM_POST_STATES-1:0]                   valid;
    logic [NUM_POST_STATES-1:0][POST_STATE_W-1:0] state;
  } post_bundle_t;

  // True when cur matches any qualified post-loop successor.
  function automatic logic post_hit(input post_bundle_t b,
                                    input logic [POST_STATE_W-1:0] cur);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < int'(NUM_POST_STATES); i++) begin
      hit = hit | (b.valid[i] & (b.state[i] == cur));
    end
    return hit;
  endfunction

endpackage

// File: rtl/seq_loop_stall_wdog.sv
// Stall watchdog: counts consecutive cycles with an unchanged observed state
// and raises a sticky flag once the limit is reached.
module seq_loop_stall_wdog import seq_loop_pkg::*; #(
  parameter int unsigned FSM_WIDTH   = 2,
  parameter int unsigned STALL_LIMIT = 1024
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [FSM_WIDTH-1:0] i_cur_state,
  input  logic [FSM_WIDTH-1:0] i_prev_state,
  input  loop_state_e          i_fsm_state,
  input  logic                 i_one_state_loop,
  output logic                 o_stall
);

  localparam int unsigned CntW = (STALL_LIMIT > 2) ? $clog2(STALL_LIMIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STALL_LIMIT - 1);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_next;
  logic            r_stall;
  logic            w_count_en;

  // A one-state loop legitimately sits in one state, and DONE is terminal.
  assign w_count_en = (i_cur_state == i_prev_state) && (i_fsm_state != StDone) &&
                      !(i_one_state_loop && (i_fsm_state == StInLoop));

  // Next count: clear on change or suppression, saturate at the limit.
  always_comb begin
    w_cnt_next = r_cnt;
    if (!w_count_en) begin
      w_cnt_next = '0;
    end else if (r_cnt != CntMax) begin
      w_cnt_next = r_cnt + CntW'(1);
    end
  end

  // Counter and sticky stall flag.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt   <= '0;
      r_stall <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_stall <= r_stall | (w_count_en && (w_cnt_next == CntMax));
    end
  end

  assign o_stall = r_stall;

endmodule

// File: rtl/seq_loop_tracker.sv
// Sequential-loop tracker: turns observed FSM state transitions into loop
// event pulses, iteration/entry counters, a stall flag and exit-error flag.
module seq_loop_tracker #(
  parameter int unsigned FSM_WIDTH   = 2,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned STALL_LIMIT = 1024
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [FSM_WIDTH-1:0] i_cur_state,
  input  logic                 i_pre_states_valid,
  input  logic [FSM_WIDTH-1:0] i_pre_loop_state0,
  input  logic [4:0]           i_post_states_valid,
  input  logic [FSM_WIDTH-1:0] i_post_loop_state0,
  input  logic [FSM_WIDTH-1:0] i_post_loop_state1,
  input  logic [FSM_WIDTH-1:0] i_post_loop_state2,
  input  logic [FSM_WIDTH-1:0] i_post_loop_state3,
  input  logic [FSM_WIDTH-1:0] i_post_loop_state4,
  input  logic                 i_quit_states_valid,
  input  logic [FSM_WIDTH-1:0] i_quit_loop_state0,
  input  logic [FSM_WIDTH-1:0] i_loop_quit_state,
  input  logic [FSM_WIDTH-1:0] i_iter_start_state,
  input  logic                 i_iter_end_states_valid,
  input  logic [FSM_WIDTH-1:0] i_iter_end_state0,
  input  logic                 i_one_state_loop,
  input  logic                 i_one_state_block,
  input  logic                 i_finish,
  output logic                 o_loop_enter,
  output logic                 o_iter_done,
  output logic                 o_loop_exit,
  output logic                 o_in_loop,
  output logic [CNT_WIDTH-1:0] o_iter_count,
  output logic [CNT_WIDTH-1:0] o_entry_count,
  output logic                 o_stall,
  output logic                 o_err_bad_exit,
  output logic                 o_done
);

  import seq_loop_pkg::*;

  loop_state_e            r_state;
  loop_state_e            w_state_next;
  logic [FSM_WIDTH-1:0]   r_prev_state;
  logic                   r_loop_enter;
  logic                   r_iter_done;
  logic                   r_loop_exit;
  logic                   r_in_loop;
  logic                   r_err_bad_exit;
  logic                   r_done;
  logic [CNT_WIDTH-1:0]   r_iter_count;
  logic [CNT_WIDTH-1:0]   r_entry_count;
  logic [CNT_WIDTH-1:0]   w_iter_count_next;
  logic [CNT_WIDTH-1:0]   w_entry_count_next;
  logic                   w_enter;
  logic                   w_iter;
  logic                   w_exit;
  logic                   w_bad_exit;
  logic                   w_stall;
  post_bundle_t           w_post;
  logic                   w_post_hit;
  logic                   w_at_start;
  logic                   w_enter_hit;
  logic                   w_iter_hit;
  logic                   w_exit_norm;
  logic                   w_exit_quit;
  logic                   w_unused_one_state_block;

  // Carried in the observation bundle; no tracker behaviour depends on it.
  assign w_unused_one_state_block = i_one_state_block;

  // Pack the post-loop successors into the shared bundle.
  always_comb begin
    w_post          = '0;
    w_post.valid    = i_post_states_valid;
    w_post.state[0] = POST_STATE_W'(i_post_loop_state0);
    w_post.state[1] = POST_STATE_W'(i_post_loop_state1);
    w_post.state[2] = POST_STATE_W'(i_post_loop_state2);
    w_post.state[3] = POST_STATE_W'(i_post_loop_state3);
    w_post.state[4] = POST_STATE_W'(i_post_loop_state4);
  end

  assign w_post_hit  = post_hit(w_post, POST_STATE_W'(i_cur_state));
  assign w_at_start  = (i_cur_state == i_iter_start_state);
  assign w_enter_hit = w_at_start &&
                       (!i_pre_states_valid || (r_prev_state == i_pre_loop_state0));
  assign w_iter_hit  = (i_iter_end_states_valid && (r_prev_state == i_iter_end_state0) &&
                        w_at_start) ||
                       (i_one_state_loop && (r_prev_state == i_iter_start_state) && w_at_start);
  assign w_exit_norm = (r_prev_state == i_loop_quit_state) && w_post_hit;
  assign w_exit_quit = i_quit_states_valid && (r_prev_state == i_quit_loop_state0) &&
                       w_post_hit;

  // Next-state and event decode; exit outranks iteration, which outranks error.
  always_comb begin
    w_state_next       = r_state;
    w_enter            = 1'b0;
    w_iter             = 1'b0;
    w_exit             = 1'b0;
    w_bad_exit         = 1'b0;
    w_iter_count_next  = r_iter_count;
    w_entry_count_next = r_entry_count;
    unique case (r_state)
      StIdle: begin
        if (w_enter_hit) begin
          w_enter            = 1'b1;
          w_state_next       = StInLoop;
          w_iter_count_next  = '0;
          w_entry_count_next = r_entry_count + CNT_WIDTH'(1);
        end
      end
      StInLoop: begin
        if (w_exit_norm || w_exit_quit) begin
          w_exit       = 1'b1;
          w_state_next = StIdle;
          // A normal exit closes out the final iteration; a quit does not.
          if (w_exit_norm) begin
            w_iter_count_next = r_iter_count + CNT_WIDTH'(1);
          end
        end else if (w_iter_hit) begin
          w_iter            = 1'b1;
          w_iter_count_next = r_iter_count + CNT_WIDTH'(1);
        end else if (w_post_hit) begin
          w_bad_exit   = 1'b1;
          w_state_next = StIdle;
        end
      end
      StDone: begin
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
    // finish overrides the transition but not this cycle's events.
    if (i_finish) begin
      w_state_next = StDone;
    end
  end

  // State, registered pulses, counters and sticky flags.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state        <= StIdle;
      r_prev_state   <= '0;
      r_loop_enter   <= 1'b0;
      r_iter_done    <= 1'b0;
      r_loop_exit    <= 1'b0;
      r_in_loop      <= 1'b0;
      r_err_bad_exit <= 1'b0;
      r_done         <= 1'b0;
      r_iter_count   <= '0;
      r_entry_count  <= '0;
    end else begin
      r_state        <= w_state_next;
      r_prev_state   <= i_cur_state;
      r_loop_enter   <= w_enter;
      r_iter_done    <= w_iter;
      r_loop_exit    <= w_exit;
      r_in_loop      <= (w_state_next == StInLoop);
      r_err_bad_exit <= r_err_bad_exit | w_bad_exit;
      r_done         <= r_done | i_finish;
      r_iter_count   <= w_iter_count_next;
      r_entry_count  <= w_entry_count_next;
    end
  end

  seq_loop_stall_wdog #(
    .FSM_WIDTH   (FSM_WIDTH),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_stall_wdog (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_cur_state      (i_cur_state),
    .i_prev_state     (r_prev_state),
    .i_fsm_state      (r_state),
    .i_one_state_loop (i_one_state_loop),
    .o_stall          (w_stall)
  );

  assign o_loop_enter   = r_loop_enter;
  assign o_iter_done    = r_iter_done;
  assign o_loop_exit    = r_loop_exit;
  assign o_in_loop      = r_in_loop;
  assign o_iter_count   = r_iter_count;
  assign o_entry_count  = r_entry_count;
  assign o_stall        = w_stall;
  assign o_err_bad_exit = r_err_bad_exit;
  assign o_done         = r_done;

endmodule

// File: tb/tb_seq_loop_tracker.sv
// Bench for seq_loop_tracker: vector table, directed corner sequences and a
// randomized run against a rule-level reference model.
module tb_seq_loop_tracker;

  localparam int unsigned FW = 2;
  localparam int unsigned CW = 4;
  localparam int unsigned SL = 8;

  logic          clk;
  logic          rst_n;
  logic [FW-1:0] cur;
  logic          pre_v;
  logic [FW-1:0] pre;
  logic [4:0]    post_v;
  logic [FW-1:0] post_st [5];
  logic          quit_v;
  logic [FW-1:0] quit0;
  logic [FW-1:0] lq;
  logic [FW-1:0] start;
  logic          end_v;
  logic [FW-1:0] end0;
  logic          osl;
  logic          osb;
  logic          fin;

  logic          loop_enter, iter_done, loop_exit, in_loop, stall, err_bad_exit, done;
  logic [CW-1:0] iter_count, entry_count;

  int n_checks;
  int n_pass;

  seq_loop_tracker #(
    .FSM_WIDTH   (FW),
    .CNT_WIDTH   (CW),
    .STALL_LIMIT (SL)
  ) dut (
    .i_clock                 (clk),
    .i_reset                 (rst_n),
    .i_cur_state             (cur),
    .i_pre_states_valid      (pre_v),
    .i_pre_loop_state0       (pre),
    .i_post_states_valid     (post_v),
    .i_post_loop_state0      (post_st[0]),
    .i_post_loop_state1      (post_st[1]),
    .i_post_loop_state2      (post_st[2]),
    .i_post_loop_state3      (post_st[3]),
    .i_post_loop_state4      (post_st[4]),
    .i_quit_states_valid     (quit_v),
    .i_quit_loop_state0      (quit0),
    .i_loop_quit_state       (lq),
    .i_iter_start_state      (start),
    .i_iter_end_states_valid (end_v),
    .i_iter_end_state0       (end0),
    .i_one_state_loop        (osl),
    .i_one_state_block       (osb),
    .i_finish                (fin),
    .o_loop_enter            (loop_enter),
    .o_iter_done             (iter_done),
    .o_loop_exit             (loop_exit),
    .o_in_loop               (in_loop),
    .o_iter_count            (iter_count),
    .o_entry_count           (entry_count),
    .o_stall                 (stall),
    .o_err_bad_exit          (err_bad_exit),
    .o_done                  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag order: enter, iter, exit, in_loop, stall, err, done.
  function automatic logic [6:0] flags();
    return {loop_enter, iter_done, loop_exit, in_loop, stall, err_bad_exit, done};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  int m_mode;  // 0 idle, 1 looping, 2 finished
  int m_prev, m_icnt, m_ecnt, m_run;
  bit m_enter, m_iter, m_exit, m_inloop, m_stall, m_err, m_done;

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_icnt = 0; m_ecnt = 0; m_run = 1;
    m_enter = 0; m_iter = 0; m_exit = 0; m_inloop = 0;
    m_stall = 0; m_err = 0; m_done = 0;
  endtask

  function automatic bit m_post_hit(int c);
    bit h = 0;
    for (int i = 0; i < 5; i++) if (post_v[i] && int'(post_st[i]) == c) h = 1;
    return h;
  endfunction

  task automatic model_step(input int c, input bit f);
    bit ph, enter_ok, exit_n, exit_q, iter_ok, eligible;
    int mode_before;
    ph       = m_post_hit(c);
    enter_ok = (c == int'(start)) && (!pre_v || m_prev == int'(pre));
    exit_n   = (m_prev == int'(lq)) && ph;
    exit_q   = quit_v && (m_prev == int'(quit0)) && ph;
    iter_ok  = (end_v && m_prev == int'(end0) && c == int'(start)) ||
               (osl && m_prev == int'(start) && c == int'(start));
    mode_before = m_mode;
    m_enter = 0; m_iter = 0; m_exit = 0;
    if (m_mode == 0 && enter_ok) begin
      m_enter = 1; m_icnt = 0; m_ecnt = (m_ecnt + 1) % 16; m_mode = 1;
    end else if (m_mode == 1) begin
      if (exit_n || exit_q) begin
        m_exit = 1; m_mode = 0;
        if (exit_n) m_icnt = (m_icnt + 1) % 16;
      end else if (iter_ok) begin
        m_iter = 1; m_icnt = (m_icnt + 1) % 16;
      end else if (ph) begin
        m_err = 1; m_mode = 0;
      end
    end
    // Run length of identical observations (1 = freshly changed or not counting).
    eligible = (mode_before != 2) && !(osl && mode_before == 1);
    m_run = (eligible && c == m_prev) ? m_run + 1 : 1;
    if (m_run >= int'(SL)) m_stall = 1;
    if (f) begin m_mode = 2; m_done = 1; end
    m_inloop = (m_mode == 1);
    m_prev = c;
  endtask

  // ---------------- configuration helpers ----------------
  task automatic cfg_base();
    pre_v = 1; pre = 0; start = 1; end_v = 1; end0 = 2;
    quit_v = 0; quit0 = 0; lq = 3; post_v = 5'b00001;
    for (int i = 0; i < 5; i++) post_st[i] = 0;
    osl = 0; osb = 0;
  endtask

  task automatic cfg_rand();
    pre_v = 1'($urandom_range(0, 1)); pre = FW'($urandom_range(0, 3));
    start = FW'($urandom_range(0, 3));
    end_v = 1'($urandom_range(0, 1)); end0 = FW'($urandom_range(0, 3));
    quit_v = 1'($urandom_range(0, 1)); quit0 = FW'($urandom_range(0, 3));
    lq = FW'($urandom_range(0, 3)); post_v = 5'($urandom_range(0, 31));
    for (int i = 0; i < 5; i++) post_st[i] = FW'($urandom_range(0, 3));
    osl = ($urandom_range(0, 3) == 0); osb = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst_n = 0; cur = 0; fin = 0;
    tick();
    tick();
    rst_n = 1;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [FW-1:0] cur;
    logic          fin;
    logic [6:0]    fl;
    logic [CW-1:0] icnt;
    logic [CW-1:0] ecnt;
  } vec_t;

  function automatic vec_t mk(logic [FW-1:0] c, logic f, logic [6:0] fl,
                              logic [CW-1:0] ic, logic [CW-1:0] ec);
    vec_t v;
    v.cur = c; v.fin = f; v.fl = fl; v.icnt = ic; v.ecnt = ec;
    return v;
  endfunction

  vec_t tbl [10];
  logic [6:0] acc;

  initial begin
    n_checks = 0; n_pass = 0;
    cfg_base();
    do_reset();
    chk("reset_outputs", {25'd0, flags()}, 32'd0);
    chk("reset_counts", {24'd0, iter_count, entry_count}, 32'd0);

    // Entry, iterations, normal exit: 0->1->2->1->2->1->2->3->0
    tbl[0] = mk(0, 0, 7'b0000000, 0, 0);
    tbl[1] = mk(1, 0, 7'b1001000, 0, 1);
    tbl[2] = mk(2, 0, 7'b0001000, 0, 1);
    tbl[3] = mk(1, 0, 7'b0101000, 1, 1);
    tbl[4] = mk(2, 0, 7'b0001000, 1, 1);
    tbl[5] = mk(1, 0, 7'b0101000, 2, 1);
    tbl[6] = mk(2, 0, 7'b0001000, 2, 1);
    tbl[7] = mk(3, 0, 7'b0001000, 2, 1);
    tbl[8] = mk(0, 0, 7'b0010000, 3, 1);
    tbl[9] = mk(0, 0, 7'b0000000, 3, 1);
    for (int i = 0; i < 10; i++) begin
      cur = tbl[i].cur; fin = tbl[i].fin;
      tick();
      chk($sformatf("vec%0d_flags", i), {25'd0, flags()}, {25'd0, tbl[i].fl});
      chk($sformatf("vec%0d_counts", i), {24'd0, iter_count, entry_count},
          {24'd0, tbl[i].icnt, tbl[i].ecnt});
    end

    // Early quit from state 2.
    cfg_base(); pre_v = 0; quit_v = 1; quit0 = 2;
    do_reset();
    cur = 1; tick();
    chk("quit_enter", loop_enter, 1);
    cur = 2; tick();
    cur = 0; tick();
    chk("quit_exit", loop_exit, 1);
    chk("quit_icnt", iter_count, 0);
    chk("quit_err", err_bad_exit, 0);
    chk("quit_inloop", in_loop, 0);

    // Bad exit from a state that is neither quit nor end.
    cfg_base(); end0 = 3;
    do_reset();
    cur = 1; tick();
    cur = 2; tick();
    cur = 0; tick();
    chk("bad_err", err_bad_exit, 1);
    chk("bad_noexit", loop_exit, 0);
    chk("bad_inloop", in_loop, 0);
    cur = 0; tick();
    chk("bad_sticky", err_bad_exit, 1);

    // Stall: 7 held cycles stay quiet, 8 set the flag.
    cfg_base(); pre = 3;
    do_reset();
    cur = 2;
    for (int i = 0; i < 7; i++) tick();
    chk("stall_hold7", stall, 0);
    cur = 1; tick();
    cur = 2;
    for (int i = 0; i < 7; i++) tick();
    chk("stall_hold7b", stall, 0);
    tick();
    chk("stall_hold8", stall, 1);

    // Asynchronous reset mid-loop.
    cfg_base();
    do_reset();
    cur = 1; tick();
    cur = 2; tick();
    cur = 1; tick();
    cur = 2; tick();
    cur = 1; tick();
    chk("rst_pre_icnt", iter_count, 2);
    #2 rst_n = 0;
    #1 chk("rst_async_all", {17'd0, flags(), iter_count, entry_count}, 32'd0);
    #1 rst_n = 1;
    model_reset();
    tick();
    chk("rst_reenter", loop_enter, 1);
    chk("rst_reenter_counts", {24'd0, iter_count, entry_count}, {24'd0, 4'd0, 4'd1});
    cur = 2; tick();
    cur = 1; tick();
    chk("rst_reiter", iter_count, 1);

    // finish together with a normal exit.
    cfg_base();
    do_reset();
    cur = 1; tick();
    cur = 2; tick();
    cur = 3; tick();
    cur = 0; fin = 1; tick();
    chk("fin_exit", loop_exit, 1);
    chk("fin_done", done, 1);
    chk("fin_inloop", in_loop, 0);
    chk("fin_icnt", iter_count, 1);
    fin = 0;
    acc = '0;
    for (int i = 0; i < 6; i++) begin
      cur = FW'((i % 2) + 1); tick();
      acc = acc | flags();
    end
    cur = 2;
    for (int i = 0; i < 12; i++) begin
      tick();
      acc = acc | flags();
    end
    chk("fin_quiet", {25'd0, acc}, {25'd0, 7'b0000001});

    // Randomized run against the model.
    cfg_rand();
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        cfg_rand();
        do_reset();
      end else begin
        if ($urandom_range(0, 3) == 0) cur = FW'($urandom_range(0, 3));
        fin = ($urandom_range(0, 599) == 0);
        model_step(int'(cur), fin);
        tick();
        chk($sformatf("rand%0d", n), {17'd0, flags(), iter_count, entry_count},
            {17'd0, m_enter, m_iter, m_exit, m_inloop, m_stall, m_err, m_done,
             4'(m_icnt), 4'(m_ecnt)});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
